// File: rtl/otter_wb_queue_pkg.sv
// Shared types and widths for the OTTER register-file writeback queue.
// Optional forwarding port: OTTER_WBQ_FORWARD_EN.
package otter_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // x0 is never tracked, so its bit is always left clear
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    logic [NUM_REGS-1:0] v;
    v = '0;
    if (r != '0) v[r] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/otter_wb_queue_if.sv
// Producer / register-file side bundle of the writeback queue.
// FWD_* signals exist only when OTTER_WBQ_FORWARD_EN is defined.
interface otter_wb_queue_if #(parameter int DEPTH = 4);
  import otter_wb_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  ALU_VALID;
  logic [REG_ADDR_W-1:0] ALU_DEST;
  logic [XLEN-1:0]       ALU_DATA;
  logic                  ALU_READY;
  logic                  MEM_VALID;
  logic [REG_ADDR_W-1:0] MEM_DEST;
  logic [XLEN-1:0]       MEM_DATA;
  logic                  MEM_READY;
  logic                  WB_HOLD;
  logic [REG_ADDR_W-1:0] WB_DEST_REG;
  logic [XLEN-1:0]       WB_DIN;
  logic                  WB_WRITE_ENABLE;
  logic [NUM_REGS-1:0]   PENDING;
  logic [CNT_W-1:0]      COUNT;
`ifdef OTTER_WBQ_FORWARD_EN
  logic [REG_ADDR_W-1:0] FWD_REG;
  logic                  FWD_HIT;
  logic [XLEN-1:0]       FWD_DATA;

  modport master (
    output ALU_VALID, ALU_DEST, ALU_DATA, MEM_VALID, MEM_DEST, MEM_DATA, WB_HOLD, FWD_REG,
    input  ALU_READY, MEM_READY, WB_DEST_REG, WB_DIN, WB_WRITE_ENABLE, PENDING, COUNT,
           FWD_HIT, FWD_DATA
  );
  modport slave (
    input  ALU_VALID, ALU_DEST, ALU_DATA, MEM_VALID, MEM_DEST, MEM_DATA, WB_HOLD, FWD_REG,
    output ALU_READY, MEM_READY, WB_DEST_REG, WB_DIN, WB_WRITE_ENABLE, PENDING, COUNT,
           FWD_HIT, FWD_DATA
  );
`else
  modport master (
    output ALU_VALID, ALU_DEST, ALU_DATA, MEM_VALID, MEM_DEST, MEM_DATA, WB_HOLD,
    input  ALU_READY, MEM_READY, WB_DEST_REG, WB_DIN, WB_WRITE_ENABLE, PENDING, COUNT
  );
  modport slave (
    input  ALU_VALID, ALU_DEST, ALU_DATA, MEM_VALID, MEM_DEST, MEM_DATA, WB_HOLD,
    output ALU_READY, MEM_READY, WB_DEST_REG, WB_DIN, WB_WRITE_ENABLE, PENDING, COUNT
  );
`endif

endinterface

// File: rtl/otter_wb_queue_fifo.sv
// In-order DEPTH-entry FIFO of writeback entries.
// Entries are exposed oldest-first (ent[0] is the head) with a matching valid vector.
module otter_wb_fifo
  import otter_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  output wb_entry_t [DEPTH-1:0]  ent,
  output logic      [DEPTH-1:0]  ent_valid,
  output logic                   full,
  output logic                   empty,
  output logic      [CNT_W-1:0]  count
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) tail <= tail + 1'b1;
      if (pop_ok)  head <= head + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible unless counted valid
  always_ff @(posedge clk) begin
    if (push_ok) mem[tail] <= push_entry;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    assign ent[k]       = mem[head + PTR_W'(k)];
    assign ent_valid[k] = (CNT_W'(k) < cnt);
  end

endmodule

// File: rtl/otter_wb_queue.sv
// Writeback queue for the OTTER register file: ALU/MEM arbitration, x0 drop, pending scoreboard.
// Optional youngest-entry forwarding when OTTER_WBQ_FORWARD_EN is defined.
module otter_wb_queue
  import otter_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           CLK,
  input  logic           RST,
  otter_wb_queue_if.slave wb
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t [DEPTH-1:0] ent;
  logic      [DEPTH-1:0] ent_valid;
  wb_entry_t             push_entry;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  alu_nz;
  logic                  mem_nz;
  logic                  alu_take;
  logic                  mem_take;
  logic                  pop;
  logic [NUM_REGS-1:0]   pending;

  assign alu_nz = (wb.ALU_DEST != '0);
  assign mem_nz = (wb.MEM_DEST != '0);

  // READY looks only at the registered full flag; x0 requests are always swallowed
  assign wb.ALU_READY = !full || !alu_nz;
  assign wb.MEM_READY = !mem_nz || (!full && !(wb.ALU_VALID && alu_nz));

  assign alu_take = wb.ALU_VALID && alu_nz && !full;
  assign mem_take = wb.MEM_VALID && mem_nz && !full && !(wb.ALU_VALID && alu_nz);
  assign pop      = !empty && !wb.WB_HOLD;

  always_comb begin
    push_entry = '{dest: wb.MEM_DEST, data: wb.MEM_DATA};
    if (alu_take) push_entry = '{dest: wb.ALU_DEST, data: wb.ALU_DATA};
  end

  otter_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (CLK),
    .rst        (RST),
    .push       (alu_take || mem_take),
    .push_entry (push_entry),
    .pop        (pop),
    .ent        (ent),
    .ent_valid  (ent_valid),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  assign wb.WB_WRITE_ENABLE = pop;
  assign wb.WB_DEST_REG     = empty ? '0 : ent[0].dest;
  assign wb.WB_DIN          = empty ? '0 : ent[0].data;
  assign wb.COUNT           = count;

  always_comb begin
    pending = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_valid[k]) pending = pending | reg_onehot(ent[k].dest);
    end
  end
  assign wb.PENDING = pending;

`ifdef OTTER_WBQ_FORWARD_EN
  logic            fwd_hit;
  logic [XLEN-1:0] fwd_data;

  // Scan oldest to youngest so the last match (youngest) wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (wb.FWD_REG != '0) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (ent_valid[k] && (ent[k].dest == wb.FWD_REG)) begin
          fwd_hit  = 1'b1;
          fwd_data = ent[k].data;
        end
      end
    end
  end
  assign wb.FWD_HIT  = fwd_hit;
  assign wb.FWD_DATA = fwd_data;
`endif

endmodule

// File: tb/tb_otter_wb_queue.sv
// Self-checking bench for otter_wb_queue: directed plan plus random traffic against a queue model.
module tb_otter_wb_queue;
  import otter_wb_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  otter_wb_queue_if #(.DEPTH(DEPTH)) bus ();
  otter_wb_queue #(.DEPTH(DEPTH)) dut (.CLK(CLK), .RST(RST), .wb(bus));

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t q[$];
  bit   alu_acc;
  bit   mem_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_alu(input bit v, input logic [4:0] d, input logic [31:0] x);
    bus.ALU_VALID = v; bus.ALU_DEST = d; bus.ALU_DATA = x;
  endtask

  task automatic drive_mem(input bit v, input logic [4:0] d, input logic [31:0] x);
    bus.MEM_VALID = v; bus.MEM_DEST = d; bus.MEM_DATA = x;
  endtask

  // Check all outputs at mid-cycle against the model, then advance the model over the edge
  task automatic cycle();
    logic [31:0] pend;
    bit          full;
    bit          alu_enq;
    bit          mem_enq;
    bit          deq;
    ent_t        a;
    ent_t        m;
    @(negedge CLK);
    full = (q.size() == DEPTH);
    pend = '0;
    foreach (q[i]) if (q[i].dest != 5'd0) pend[q[i].dest] = 1'b1;
    check("count", 32'(bus.COUNT), q.size());
    check("we", 32'(bus.WB_WRITE_ENABLE), 32'(q.size() != 0 && !bus.WB_HOLD));
    if (q.size() != 0) begin
      check("wb_dest", 32'(bus.WB_DEST_REG), 32'(q[0].dest));
      check("wb_din", bus.WB_DIN, q[0].data);
    end else begin
      check("wb_dest", 32'(bus.WB_DEST_REG), 0);
      check("wb_din", bus.WB_DIN, 0);
    end
    check("pending", bus.PENDING, pend);
    alu_acc = (bus.ALU_DEST == 5'd0) || !full;
    if (bus.MEM_DEST == 5'd0)                         mem_acc = 1'b1;
    else if (full)                                    mem_acc = 1'b0;
    else if (bus.ALU_VALID && bus.ALU_DEST != 5'd0)   mem_acc = 1'b0;
    else                                              mem_acc = 1'b1;
    check("alu_ready", 32'(bus.ALU_READY), 32'(alu_acc));
    check("mem_ready", 32'(bus.MEM_READY), 32'(mem_acc));
`ifdef OTTER_WBQ_FORWARD_EN
    begin
      bit          fh;
      logic [31:0] fd;
      fh = 1'b0; fd = '0;
      if (bus.FWD_REG != 5'd0)
        foreach (q[i]) if (q[i].dest == bus.FWD_REG) begin fh = 1'b1; fd = q[i].data; end
      check("fwd_hit", 32'(bus.FWD_HIT), 32'(fh));
      check("fwd_data", bus.FWD_DATA, fd);
    end
`endif
    alu_acc = alu_acc && bus.ALU_VALID;
    mem_acc = mem_acc && bus.MEM_VALID;
    alu_enq = alu_acc && bus.ALU_DEST != 5'd0;
    mem_enq = mem_acc && bus.MEM_DEST != 5'd0;
    deq     = (q.size() != 0) && !bus.WB_HOLD;
    a = '{dest: bus.ALU_DEST, data: bus.ALU_DATA};
    m = '{dest: bus.MEM_DEST, data: bus.MEM_DATA};
    @(posedge CLK);
    #1;
    if (deq) void'(q.pop_front());
    if (alu_enq) q.push_back(a);
    else if (mem_enq) q.push_back(m);
  endtask

  initial begin
    RST = 1'b1;
    drive_alu(0, 0, 0);
    drive_mem(0, 0, 0);
    bus.WB_HOLD = 1'b0;
`ifdef OTTER_WBQ_FORWARD_EN
    bus.FWD_REG = 5'd0;
`endif
    repeat (2) @(posedge CLK);
    #1;
    check("rst_count", 32'(bus.COUNT), 0);
    check("rst_we", 32'(bus.WB_WRITE_ENABLE), 0);
    check("rst_pending", bus.PENDING, 0);
    RST = 1'b0;

    // single write
    drive_alu(1, 5'd5, 32'hDEADBEEF);
    cycle();
    drive_alu(0, 0, 0);
    check("single_cnt1", 32'(bus.COUNT), 1);
    check("single_pend", bus.PENDING, 32'h20);
    cycle();
    check("single_cnt0", 32'(bus.COUNT), 0);
    check("single_pend0", bus.PENDING, 0);
    cycle();

    // arbitration: ALU wins, MEM held and accepted next cycle
    drive_alu(1, 5'd3, 32'h11);
    drive_mem(1, 5'd4, 32'h22);
    cycle();
    drive_alu(0, 0, 0);
    cycle();
    drive_mem(0, 0, 0);
    repeat (3) cycle();

    // fill and hold
    bus.WB_HOLD = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      drive_alu(1, 5'(i), 32'(100 + i));
      cycle();
    end
    drive_alu(1, 5'd5, 32'd105);
    #1;
    check("fill_cnt", 32'(bus.COUNT), DEPTH);
    check("fill_pend", bus.PENDING, 32'h1E);
    check("fill_ready5", 32'(bus.ALU_READY), 0);
    cycle();
    bus.WB_HOLD = 1'b0;
    for (int i = 0; i < 8 && !(alu_acc); i++) cycle();
    drive_alu(0, 0, 0);
    repeat (6) cycle();

    // x0 while full, then same-register ordering
    bus.WB_HOLD = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      drive_alu(1, 5'(i), 32'(200 + i));
      cycle();
    end
    drive_alu(1, 5'd0, 32'hFFFF);
    #1;
    check("x0_ready", 32'(bus.ALU_READY), 1);
    cycle();
    drive_alu(0, 0, 0);
    check("x0_cnt", 32'(bus.COUNT), DEPTH);
    check("x0_pend0", 32'(bus.PENDING[0]), 0);
    bus.WB_HOLD = 1'b0;
    repeat (5) cycle();
    drive_alu(1, 5'd7, 32'd1);
    cycle();
    drive_alu(1, 5'd7, 32'd2);
    cycle();
    drive_alu(0, 0, 0);
    check("x7_pend", 32'(bus.PENDING[7]), 1);
    check("x7_din2", bus.WB_DIN, 32'd2);
    repeat (2) cycle();

    // async reset mid-cycle with three entries queued
    bus.WB_HOLD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_alu(1, 5'(10 + i), 32'(300 + i));
      cycle();
    end
    drive_alu(0, 0, 0);
    check("pre_rst_cnt", 32'(bus.COUNT), 3);
    #2 RST = 1'b1;
    #1;
    check("arst_count", 32'(bus.COUNT), 0);
    check("arst_we", 32'(bus.WB_WRITE_ENABLE), 0);
    check("arst_pending", bus.PENDING, 0);
    check("arst_din", bus.WB_DIN, 0);
    q.delete();
    bus.WB_HOLD = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #3 RST = 1'b0;
    drive_alu(1, 5'd6, 32'h66);
    cycle();
    drive_alu(0, 0, 0);
    check("rst_lat_we", 32'(bus.WB_WRITE_ENABLE), 1);
    cycle();
    cycle();

`ifdef OTTER_WBQ_FORWARD_EN
    bus.WB_HOLD = 1'b1;
    drive_alu(1, 5'd9, 32'hA);
    cycle();
    drive_alu(1, 5'd9, 32'hB);
    cycle();
    drive_alu(0, 0, 0);
    bus.FWD_REG = 5'd9;
    #1;
    check("fwd9_hit", 32'(bus.FWD_HIT), 1);
    check("fwd9_data", bus.FWD_DATA, 32'hB);
    bus.FWD_REG = 5'd0;
    #1;
    check("fwd0_hit", 32'(bus.FWD_HIT), 0);
    check("fwd0_data", bus.FWD_DATA, 0);
    bus.WB_HOLD = 1'b0;
    repeat (3) cycle();
`endif

    // random traffic; producers hold requests until accepted
    alu_acc = 1'b1;
    mem_acc = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if (!bus.ALU_VALID || alu_acc)
        drive_alu(($urandom % 3) != 0, 5'($urandom_range(0, 7)), $urandom);
      if (!bus.MEM_VALID || mem_acc)
        drive_mem(($urandom % 2) != 0, 5'($urandom_range(0, 7)), $urandom);
      bus.WB_HOLD = (($urandom % 4) == 0);
`ifdef OTTER_WBQ_FORWARD_EN
      bus.FWD_REG = 5'($urandom_range(0, 7));
`endif
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/otter_wb_queue.md
Name: otter_wb_queue

Overview:
- Writer side of the OTTER register file's single write port.
- Accepts register writebacks from two producers: the single-cycle ALU path and the variable-latency memory/multiply path.
- Buffers them in an in-order FIFO and issues at most one write per cycle on the register file's DEST_REG/DIN/WRITE_ENABLE port.
- Publishes a per-register pending scoreboard so hazard logic can stall readers of registers with writes still in flight.

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- ALU_VALID  in  1  ALU writeback request.
- ALU_DEST  in  5  ALU destination register.
- ALU_DATA  in  32  ALU result.
- ALU_READY  out  1  ALU request accepted this cycle.
- MEM_VALID  in  1  memory/mul writeback request.
- MEM_DEST  in  5  memory destination register.
- MEM_DATA  in  32  memory result.
- MEM_READY  out  1  memory request accepted this cycle.
- WB_HOLD  in  1  freeze dequeue (debug/halt).
- WB_DEST_REG  out  5  register file write address.
- WB_DIN  out  32  register file write data.
- WB_WRITE_ENABLE  out  1  register file write strobe.
- PENDING  out  32  bit r set while any queued write targets r.
- COUNT  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset: asynchronous, active-high. Clears the queue immediately, including mid-operation; queued writes are discarded. While RST is high or the queue is empty: WB_WRITE_ENABLE=0, WB_DEST_REG=0, WB_DIN=0, PENDING=0, COUNT=0.
- Handshake: a transfer occurs on a posedge where VALID && READY; producers hold DEST/DATA stable until accepted.
- x0 requests: a request with DEST=0 gets READY=1 unconditionally and is dropped; it never enqueues or affects PENDING.
- Enqueue limit: at most one enqueue per cycle. ALU has priority.
- ALU_READY = !full || ALU_DEST==0.
- MEM_READY = MEM_DEST==0 || (!full && !(ALU_VALID && ALU_DEST!=0)).
- READY depends on the registered full flag only. There is no same-cycle pass-through when full, even if a dequeue happens that edge.
- Output: WB_* are driven from the FIFO head. WB_WRITE_ENABLE = !empty && !WB_HOLD.
- Write timing: the register file writes on the negedge mid-cycle; the head dequeues at the next posedge when WB_WRITE_ENABLE=1.
- Latency: a request accepted at posedge k into an empty queue produces WB_WRITE_ENABLE=1 during cycle k..k+1 and is retired at posedge k+1.
- Hold: while WB_HOLD=1 no dequeue occurs. The head stays presented with WB_WRITE_ENABLE=0, and enqueue continues until full.
- Simultaneous enqueue and dequeue: COUNT unchanged; legal at full only for the dequeue side, since READY is already low.
- Pointers: head/tail wrap modulo DEPTH. COUNT saturates logically at DEPTH; overflow and underflow are impossible by construction.
- Ordering: strict FIFO. Two writes to the same register retire in acceptance order, so the later value wins in the register file.
- PENDING: combinational OR over valid entries of onehot(dest), excluding bit 0.
  - An entry being dequeued still counts until the edge.
  - A same-edge enqueue to the same register keeps its bit set.

Optional Feature:
- Macro: OTTER_WBQ_FORWARD_EN.
- Defined: adds ports FWD_REG in 5, FWD_HIT out 1, FWD_DATA out 32.
  - FWD_HIT=1 when FWD_REG!=0 and a valid entry targets it.
  - FWD_DATA = data of the youngest matching entry, combinationally.
  - With no match: FWD_HIT=0, FWD_DATA=0.
- Undefined: the ports are absent and no comparator logic is built. Hazard logic must stall on PENDING.

Decomposition:
- Package otter_wb_pkg:
  - wb_entry_t packed struct {logic [4:0] dest; logic [31:0] data;}.
  - REG_ADDR_W=5, XLEN=32, NUM_REGS=32.
- Sub-module otter_wb_fifo: generic DEPTH-entry FIFO of wb_entry_t, exposing head, full, empty, count and a valid-entry vector for PENDING/forward scans.
- otter_wb_queue contains arbitration, x0 filtering, scoreboard and the optional forward logic.

Test Plan:
- Single write: ALU_VALID, DEST=5, DATA=0xDEADBEEF on an empty queue.
  -> Next cycle WB_WRITE_ENABLE=1, WB_DEST_REG=5, WB_DIN=0xDEADBEEF; PENDING[5]=1 for exactly one cycle; COUNT 1 then 0.
- Arbitration: ALU (DEST=3, 0x11) and MEM (DEST=4, 0x22) valid in the same cycle.
  -> ALU_READY=1, MEM_READY=0. Writes retire as x3=0x11 then x4=0x22 on consecutive cycles.
- Fill and hold: WB_HOLD=1 and DEPTH+1 ALU writes to x1..x5.
  -> COUNT=4, ALU_READY=0 on the fifth, PENDING=0x1E.
  -> Release hold: four writes in order, then the fifth is accepted.
- x0 and same-register ordering: ALU DEST=0 while full.
  -> Accepted, COUNT unchanged, PENDING[0]=0.
  -> Then writes x7=1 and x7=2: retire 1 then 2; PENDING[7] stays set until the second retires.
- Async reset: assert RST mid-cycle with COUNT=3.
  -> Outputs zero immediately; after release the queue is empty and the next write has 1-cycle latency.
- With OTTER_WBQ_FORWARD_EN: queue x9=0xA then x9=0xB under hold, FWD_REG=9.
  -> FWD_HIT=1, FWD_DATA=0xB.
  -> FWD_REG=0: FWD_HIT=0, FWD_DATA=0.
